seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one BCD-to-7-segment decoder among DIGITS common-anode/cathode digit positions. Holds a per-digit 4-bit BCD register file written by the host and cycles through the digits, presenting one digit's code to the shared decoder while enabling exactly one digit driver. A blanking gap between slots prevents ghosting. It sits between the host logic and the combinational segment decoder plus digit drivers.

---
 rtl/seg_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a shared BCD-to-7-segment
// decoder. It holds a per-digit BCD register file, walks the digit positions
// with a blanking gap before each drive slot, and pulses frame_tick once per
// complete frame.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zeros).
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int IW           = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [3:0]        wr_data,
  output logic [3:0]        bcd_out,
  output logic [DIGITS-1:0] an,
  output logic              seg_blank,
  output logic              frame_tick
);

  localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] P_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] B_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [IW:0]   DIGITS_W = (IW + 1)'(DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [3:0]        digit_q [DIGITS];
  logic [3:0]        digit_d [DIGITS];
  logic [DIGITS-1:0] an_q, an_d;
  logic              seg_blank_q, seg_blank_d;
  logic              frame_tick_q, frame_tick_d;
  logic              suppress;

  // Register file next value: host write to an in-range index.
  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit_d[i] = digit_q[i];
    end
    if (wr_en && ({1'b0, wr_idx} < DIGITS_W)) begin
      digit_d[wr_idx] = wr_data;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_above;

  // zero_above[i]: digit i and every digit above it hold 0.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    zero_above = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      all_zero = all_zero && (digit_d[DIGITS-1-k] == 4'd0);
      zero_above[DIGITS-1-k] = all_zero;
    end
  end

  // Suppress non-decimal codes and leading zeros; digit 0 always shows.
  always_comb begin
    suppress = (digit_d[scan_idx_d] > 4'd9) ||
               ((scan_idx_d != '0) && zero_above[scan_idx_d]);
  end
`else
  // Suppress non-decimal codes only.
  always_comb begin
    suppress = (digit_d[scan_idx_d] > 4'd9);
  end
`endif

  // Scan sequencing and registered output decode.
  // Outputs are decoded from the next state and post-write register values, so
  // an/seg_blank line up with the state and with the live digit contents.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scan_idx_d   = scan_idx_q;
    frame_tick_d = 1'b0;
    if (!enable) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      scan_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          scan_idx_d = '0;
        end
        ST_BLANK: begin
          if (cnt_q == B_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == P_LAST) begin
            state_d      = ST_BLANK;
            cnt_d        = '0;
            scan_idx_d   = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
            frame_tick_d = (scan_idx_q == LAST_IDX);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          scan_idx_d = '0;
        end
      endcase
    end

    an_d        = '0;
    seg_blank_d = 1'b1;
    if ((state_d == ST_DRIVE) && !suppress) begin
      an_d[scan_idx_d] = 1'b1;
      seg_blank_d      = 1'b0;
    end
  end

  // State, counters, register file and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      scan_idx_q   <= '0;
      an_q         <= '0;
      seg_blank_q  <= 1'b1;
      frame_tick_q <= 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        digit_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_idx_q   <= scan_idx_d;
      an_q         <= an_d;
      seg_blank_q  <= seg_blank_d;
      frame_tick_q <= frame_tick_d;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

  assign bcd_out    = digit_q[scan_idx_q];
  assign an         = an_q;
  assign seg_blank  = seg_blank_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, PRESCALE=3, BLANK_CYCLES=1).
// A time-based model (elapsed cycles since scanning began) predicts outputs
// every cycle; directed steps add hand-computed literal expectations.
module tb_seg_scan_ctrl;

  localparam int D     = 4;
  localparam int P     = 3;
  localparam int B     = 1;
  localparam int SLOT  = B + P;
  localparam int FRAME = D * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_data;
  logic [3:0] bcd_out;
  logic [3:0] an;
  logic       seg_blank;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(
    .DIGITS      (D),
    .PRESCALE    (P),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .bcd_out   (bcd_out),
    .an        (an),
    .seg_blank (seg_blank),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: digit contents, whether scanning, cycles since scan start.
  int  mdig [D];
  bit  m_run   = 1'b0;
  int  m_t     = 0;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) mdig[i] = 0;
      m_run   = 1'b0;
      m_t     = 0;
      m_valid = 1'b1;
    end else begin
      if (wr_en && (int'(wr_idx) < D)) mdig[wr_idx] = int'(wr_data);
      if (!enable) begin
        m_run = 1'b0;
        m_t   = 0;
      end else if (m_run) begin
        m_t++;
      end else begin
        m_run = 1'b1;
        m_t   = 0;
      end
    end
  end

  function automatic bit shown(input int idx);
    bit ok;
    ok = (mdig[idx] <= 9);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0) begin
      bit any_nz;
      any_nz = 1'b0;
      for (int j = idx; j < D; j++) if (mdig[j] != 0) any_nz = 1'b1;
      ok = ok && any_nz;
    end
`endif
    return ok;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int  e_an, e_blank, e_tick, e_bcd, idx;
    bit  drv;
    if (m_valid) begin
      if (!m_run) begin
        e_an = 0; e_blank = 1; e_tick = 0; e_bcd = mdig[0];
      end else begin
        idx     = (m_t / SLOT) % D;
        drv     = (m_t % SLOT) >= B;
        e_bcd   = mdig[idx];
        e_an    = (drv && shown(idx)) ? (1 << idx) : 0;
        e_blank = (drv && shown(idx)) ? 0 : 1;
        e_tick  = (m_t > 0 && (m_t % FRAME) == 0) ? 1 : 0;
      end
      chk("model_an", int'(an), e_an);
      chk("model_seg_blank", int'(seg_blank), e_blank);
      chk("model_frame_tick", int'(frame_tick), e_tick);
      chk("model_bcd_out", int'(bcd_out), e_bcd);
    end
  end

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    chk(name, int'(frame_tick), 1);
  endtask

  int exp_an [16] = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8};

  initial begin
    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_an", int'(an), 0);
    chk("reset_seg_blank", int'(seg_blank), 1);
    chk("reset_frame_tick", int'(frame_tick), 0);
    chk("reset_bcd_out", int'(bcd_out), 0);
    rst = 1'b0;

    // Load 1,2,3,4 and start scanning.
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_idx = 2'(i); wr_data = 4'(i + 1);
      @(negedge clk);
    end
    wr_en  = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("seq_an", int'(an), exp_an[k]);
      chk("seq_bcd", int'(bcd_out), k / 4 + 1);
      chk("seq_no_tick", int'(frame_tick), 0);
    end
    @(negedge clk);
    chk("frame1_tick", int'(frame_tick), 1);
    chk("frame1_an", int'(an), 0);
    chk("frame1_bcd", int'(bcd_out), 1);

    // Digit 2 = 12: slot 2 dark, frame length unchanged.
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 4'd12;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("sup_an", int'(an), 0);
        chk("sup_seg_blank", int'(seg_blank), 1);
        chk("sup_bcd", int'(bcd_out), 12);
      end
      if (k == 6) chk("sup_other_an", int'(an), 2);
    end
    chk("frame2_tick", int'(frame_tick), 1);

    // Drop enable during slot 2 drive, restore after 5 dark cycles.
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dark_an", int'(an), 0);
    chk("dark_seg_blank", int'(seg_blank), 1);
    chk("dark_bcd", int'(bcd_out), 1);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("restart_blank_an", int'(an), 0);
    chk("restart_blank_seg", int'(seg_blank), 1);
    @(negedge clk);
    chk("restart_an", int'(an), 1);

    // Overwrite digit 1 while it is being driven.
    repeat (4) @(negedge clk);
    chk("live_pre_an", int'(an), 2);
    wr_en = 1'b1; wr_idx = 2'd1; wr_data = 4'd7;
    @(negedge clk);
    wr_en = 1'b0;
    chk("live_bcd", int'(bcd_out), 7);
    chk("live_an", int'(an), 2);
    @(negedge clk);
    chk("live_an_hold", int'(an), 2);
    @(negedge clk);
    chk("live_slot_end_an", int'(an), 0);
    chk("live_next_bcd", int'(bcd_out), 12);

    // Values 0,5,0,0 for leading-zero behaviour.
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_idx = 2'(i); wr_data = (i == 1) ? 4'd5 : 4'd0;
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_tick("lz_tick");
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1)  chk("lz_d0_an", int'(an), 1);
      if (k == 5)  chk("lz_d1_an", int'(an), 2);
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 9)  chk("lz_d2_an", int'(an), 0);
      if (k == 13) chk("lz_d3_an", int'(an), 0);
`else
      if (k == 9)  chk("lz_d2_an", int'(an), 4);
      if (k == 13) chk("lz_d3_an", int'(an), 8);
`endif
    end

    // Reset mid-frame clears everything.
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", int'(an), 0);
    chk("midrst_seg_blank", int'(seg_blank), 1);
    chk("midrst_tick", int'(frame_tick), 0);
    chk("midrst_bcd", int'(bcd_out), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("postrst_d1_bcd", int'(bcd_out), 0);
    repeat (14) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
